// File: rtl/alu_seq_disp_if.sv
// Operand/op request and registered result/flag response bundle between a
// requester and the alu_seq_disp compute block.
interface alu_seq_disp_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] result;
    logic [3:0]       alu_flags;
    logic             out_valid;

    modport master (
        output in_valid, a, b, alu_control,
        input  in_ready, result, alu_flags, out_valid
    );

    modport slave (
        input  in_valid, a, b, alu_control,
        output in_ready, result, alu_flags, out_valid
    );
endinterface

// File: rtl/alu_seq_disp.sv
// Registered ALU (1 cycle, MUL WIDTH+1 cycles; in_ready low during MUL) with a muxed
// seven-segment sign/hex display of the held result. ALU_SEQ_DISP_LZB_EN enables leading-zero blanking.
module alu_seq_disp #(
    parameter int WIDTH        = 8,
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              reset,
    alu_seq_disp_if.slave     bus,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int DIW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NW  = DIGITS * 4;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [SHW-1:0]   shamt;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return {r[WIDTH-1], r == '0, c, v};
    endfunction

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.result    = result_q;
    assign bus.alu_flags = flags_q;
    assign bus.out_valid = out_valid_q;

    assign shamt    = bus.b[SHW-1:0];
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        add_full = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (bus.alu_control)
            3'b000: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b001: begin
                // Carry is the inverted borrow, so C=1 means a >= b unsigned.
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = ~sub_full[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b010:  alu_res = bus.a & bus.b;
            3'b011:  alu_res = bus.a | bus.b;
            3'b100:  alu_res = bus.a ^ bus.b;
            3'b101:  alu_res = bus.a << shamt;
            3'b110:  alu_res = WIDTH'($signed(bus.a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            result_q    <= '0;
            flags_q     <= 4'b0100;
            out_valid_q <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (bus.alu_control == 3'b111) begin
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            acc    <= '0;
                            count  <= '0;
                            state  <= MUL;
                        end else begin
                            result_q    <= alu_res;
                            flags_q     <= mk_flags(alu_res, alu_c, alu_v);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        result_q    <= acc_next;
                        flags_q     <= mk_flags(acc_next, 1'b0, 1'b0);
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    logic [REFRESH_BITS-1:0] prescaler;
    logic [DIW-1:0]          digit_idx;
    logic [WIDTH-1:0]        mag;
    logic [NW-1:0]           mag_ext;
    logic [3:0]              nib;
    logic [6:0]              glyph;
    logic                    dp;

    // Two's-complement negate of the most negative value wraps to itself, shown as its unsigned magnitude.
    assign mag     = result_q[WIDTH-1] ? (~result_q + 1'b1) : result_q;
    assign mag_ext = NW'(mag);
    assign nib     = mag_ext[{digit_idx, 2'b00} +: 4];
    assign dp      = !((digit_idx == DIW'(DIGITS - 1)) && result_q[WIDTH-1]);

`ifdef ALU_SEQ_DISP_LZB_EN
    logic blank;
    assign blank = (digit_idx != '0) && ((mag_ext >> {digit_idx, 2'b00}) == '0);
    assign glyph = blank ? 7'b1111111 : hex_glyph(nib);
`else
    assign glyph = hex_glyph(nib);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            digit_idx <= '0;
            an        <= ~DIGITS'(1);
            seg       <= 8'b1_0000001;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (&prescaler)
                digit_idx <= (digit_idx == DIW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            an  <= ~(DIGITS'(1) << digit_idx);
            seg <= {dp, glyph};
        end
    end
endmodule

// File: tb/tb_alu_seq_disp.sv
// Scoreboard bench for alu_seq_disp: directed vectors push expected result/flags, a negedge monitor pops on out_valid.
module tb_alu_seq_disp;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an;
    logic [7:0] seg;

    alu_seq_disp_if #(.WIDTH(8)) bus ();

    alu_seq_disp #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flags;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0]  gl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [15:0] mag_tb;
    logic        neg_tb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.a           = x;
        bus.b           = y;
    endtask

    task automatic push(input logic [7:0] r, input logic [3:0] f);
        exp_q.push_back('{res: r, flags: f});
    endtask

    function automatic logic [7:0] exp_seg(input int d);
        logic [15:0] sh;
        logic [6:0]  g;
        logic        p;
        sh = mag_tb >> (4 * d);
        g  = gl[sh[3:0]];
`ifdef ALU_SEQ_DISP_LZB_EN
        if (d != 0 && sh == 16'h0) g = 7'b1111111;
`endif
        p = (d == 3 && neg_tb) ? 1'b0 : 1'b1;
        return {p, g};
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got result=%0h flags=%b, expected no completion", bus.result, bus.alu_flags);
            end else begin
                e = exp_q.pop_front();
                if (bus.result !== e.res || bus.alu_flags !== e.flags) begin
                    errors++;
                    $display("FAIL scoreboard: got result=%0h flags=%b, expected result=%0h flags=%b",
                             bus.result, bus.alu_flags, e.res, e.flags);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // op, a, b, expected result, expected flags
    logic [2:0] v_op  [9] = '{3'b101, 3'b110, 3'b010, 3'b011, 3'b100, 3'b000, 3'b001, 3'b101, 3'b110};
    logic [7:0] v_a   [9] = '{8'h81,  8'h81,  8'hF0,  8'hF0,  8'hAA,  8'hFF,  8'h80,  8'h01,  8'h40};
    logic [7:0] v_b   [9] = '{8'h09,  8'h02,  8'h3C,  8'h0F,  8'hAA,  8'h01,  8'h01,  8'h07,  8'h03};
    logic [7:0] v_res [9] = '{8'h02,  8'hE0,  8'h30,  8'hFF,  8'h00,  8'h00,  8'h7F,  8'h80,  8'h08};
    logic [3:0] v_flg [9] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0100, 4'b0110, 4'b0011, 4'b1000, 4'b0000};

    initial begin
        int         prev, run, changes, zeros, idx;
        logic [3:0] prev_an, seen;

        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.alu_control = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", bus.result, 8'h00);
        chk("reset_flags", bus.alu_flags, 4'b0100);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_in_ready", bus.in_ready, 1'b0);
        chk("reset_an", an, 4'b1110);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", bus.in_ready, 1'b1);

        // Add with signed overflow, then out_valid drops.
        @(posedge clk); #1;
        drive(3'b000, 8'h7F, 8'h01); push(8'h80, 4'b1001);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk); chk("add_out_valid", bus.out_valid, 1'b1);
        @(negedge clk); chk("out_valid_drop", bus.out_valid, 1'b0);

        // Back-to-back subtracts.
        @(posedge clk); #1;
        drive(3'b001, 8'h05, 8'h05); push(8'h00, 4'b0110);
        @(posedge clk); #1;
        drive(3'b001, 8'h03, 8'h05); push(8'hFE, 4'b1000);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk); chk("sub_second_out_valid", bus.out_valid, 1'b1);

        // Shifts, logic ops, carry/borrow corners issued every cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            drive(v_op[i], v_a[i], v_b[i]); push(v_res[i], v_flg[i]);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained_1", exp_q.size(), 0);

        // Multiply with a competing op held valid throughout.
        @(posedge clk); #1;
        drive(3'b111, 8'h0D, 8'h0B); push(8'h8F, 4'b1000);
        @(posedge clk); #1;
        drive(3'b000, 8'h01, 8'h01); push(8'h02, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("mul_in_ready_low", bus.in_ready, 1'b0);
        end
        @(negedge clk);
        chk("mul_done_in_ready", bus.in_ready, 1'b1);
        chk("mul_done_out_valid", bus.out_valid, 1'b1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained_2", exp_q.size(), 0);

        // Negative result 0xF6 on the display: magnitude 0x0A, sign on leftmost digit.
        @(posedge clk); #1;
        drive(3'b001, 8'h00, 8'h0A); push(8'hF6, 4'b1000);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        mag_tb  = 16'h000A;
        neg_tb  = 1'b1;
        prev    = -1;
        run     = 0;
        changes = 0;
        seen    = '0;
        prev_an = an;
        for (int k = 0; k < 40; k++) begin
            if (k != 0) @(negedge clk);
            zeros = 0;
            idx   = 0;
            for (int j = 0; j < 4; j++) if (!an[j]) begin zeros++; idx = j; end
            chk("an_one_hot", zeros, 1);
            if (zeros == 1) begin
                seen[idx] = 1'b1;
                chk($sformatf("seg_digit%0d", idx), seg, exp_seg(idx));
                if (k != 0 && an != prev_an) begin
                    if (prev >= 0) chk("digit_order", idx, (prev + 1) % 4);
                    if (changes > 0) chk("digit_period", run, 4);
                    changes++;
                    run = 0;
                end
                prev    = idx;
                prev_an = an;
                run++;
            end
        end
        chk("all_digits_seen", seen, 4'hF);

        // Reset during the 4th MUL cycle aborts the multiply.
        @(posedge clk); #1;
        drive(3'b111, 8'h05, 8'h03);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_result", bus.result, 8'h00);
        chk("abort_flags", bus.alu_flags, 4'b0100);
        chk("abort_in_ready_in_reset", bus.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_after", bus.in_ready, 1'b1);
        repeat (12) @(negedge clk);
        chk("abort_result_held", bus.result, 8'h00);
        chk("abort_flags_held", bus.alu_flags, 4'b0100);
        chk("queue_drained_final", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
